// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: cache-to-memory controller with blocking read-miss refill and a write-through FIFO store buffer
module data_mem_ctrl #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  input  logic                              req_wen,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [31:0]                       req_wdata,
  input  logic [2:0]                        req_width,
  input  logic                              cache_hit,
  output logic                              stall,
  output logic [31:0]                       refill_data,
  output logic                              refill_valid,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [31:0]                       mem_wdata,
  output logic [2:0]                        mem_width,
  input  logic                              mem_ack,
  input  logic [31:0]                       mem_rdata,
  output logic [$clog2(WB_DEPTH+1)-1:0]     wb_count
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH+1);
  typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] q_addr [WB_DEPTH];
  logic [31:0] q_data [WB_DEPTH];
  logic [2:0] q_width [WB_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic full, empty, draining, push, pop, rd_miss, st_req;
  assign wb_count = count;
  assign full = count == CW'(WB_DEPTH);
  assign empty = count == '0;
  assign draining = ~empty & (state == IDLE | state == DRAIN);
  assign pop = draining & mem_ack;
  assign rd_miss = req_valid & ~req_wen & ~cache_hit;
  assign st_req = req_valid & req_wen;
  // a full buffer refuses the store this cycle even if a pop frees a slot; it enqueues next cycle
  assign push = state == IDLE & st_req & ~full;
  assign stall = ~rst & (state == IDLE ? (rd_miss | (st_req & full)) : state != RESP);
  assign refill_valid = state == RESP;
  assign mem_req = state == READ | draining;
  assign mem_we = draining;
  assign mem_addr = state == READ ? {req_addr[ADDR_WIDTH-1:2], 2'b00} : draining ? q_addr[rd_ptr] : '0;
  assign mem_wdata = draining ? q_data[rd_ptr] : '0;
  assign mem_width = draining ? q_width[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= req_addr;
      q_data[wr_ptr] <= req_wdata;
      q_width[wr_ptr] <= req_width;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      refill_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      case (state)
        IDLE: if (rd_miss) state <= empty ? READ : DRAIN;
        // the read waits until every older store has been acknowledged
        DRAIN: if (empty | (count == CW'(1) & pop)) state <= READ;
        READ: if (mem_ack) begin
          refill_data <= mem_rdata;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench with a delayed-ack memory model checking transaction order, refills and stalls
module tb_data_mem_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wen = 0, cache_hit = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0] req_width = 0;
  logic stall, refill_valid, mem_req, mem_we;
  logic [31:0] refill_data, mem_addr, mem_wdata;
  logic [2:0] mem_width, wb_count;
  logic mem_ack = 0;
  logic [31:0] mem_rdata = 0;

  data_mem_ctrl #(.WB_DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_width(req_width), .cache_hit(cache_hit), .stall(stall),
    .refill_data(refill_data), .refill_valid(refill_valid), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we;
    logic [31:0] addr, data;
    logic [2:0] width;
  } txn_t;
  txn_t exp_q[$];
  logic [31:0] exp_rf[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_mem [logic [31:0]];
  int n_vec = 0, n_err = 0;
  int ack_delay = 1, wcnt = 0;
  bit hold = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] w, input logic [1:0] off);
    logic [31:0] r = old;
    if (w[1:0] == 2'b00) r = d;
    else if (w[1:0] == 2'b01) begin
      if (off[1]) r[31:16] = d[15:0];
      else r[15:0] = d[15:0];
    end else r[8*off +: 8] = d[7:0];
    return r;
  endfunction

  // memory model: acks the ack_delay-th cycle of a request, then idles one cycle
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 0;
      wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 0;
      wcnt = 0;
    end else if (mem_req && !hold) begin
      wcnt++;
      if (wcnt >= ack_delay) begin
        txn_t e;
        logic [31:0] k;
        check("txn_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("txn_we", mem_we, e.we);
          check("txn_addr", mem_addr, e.addr);
          k = {mem_addr[31:2], 2'b00};
          if (e.we) begin
            check("txn_wdata", mem_wdata, e.data);
            check("txn_width", mem_width, e.width);
            mem[k] = merge(mem.exists(k) ? mem[k] : 32'h0, mem_wdata, mem_width, mem_addr[1:0]);
          end else mem_rdata = mem.exists(k) ? mem[k] : 32'h0;
        end
        mem_ack = 1;
      end
    end else wcnt = 0;
  end

  always @(negedge clk) begin
    if (!rst && refill_valid) begin
      check("refill_expected", exp_rf.size() > 0, 1);
      if (exp_rf.size() > 0) check("refill_data", refill_data, exp_rf.pop_front());
    end
  end

  task automatic expect_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] w, input logic hit);
    logic [31:0] k = {a[31:2], 2'b00};
    if (we) begin
      exp_q.push_back('{we: 1'b1, addr: a, data: d, width: w});
      exp_mem[k] = merge(exp_mem.exists(k) ? exp_mem[k] : 32'h0, d, w, a[1:0]);
    end else if (!hit) begin
      exp_q.push_back('{we: 1'b0, addr: k, data: 32'h0, width: 3'b0});
      exp_rf.push_back(exp_mem.exists(k) ? exp_mem[k] : 32'h0);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] w, input logic hit);
    req_valid = 1; req_wen = we; req_addr = a; req_wdata = d; req_width = w; cache_hit = hit;
    expect_req(we, a, d, w, hit);
  endtask

  // call just after a rising edge; returns once the request completes
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] w, input logic hit, output int stalls);
    logic s;
    bit done = 0;
    drive(we, a, d, w, hit);
    stalls = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      if (!s) done = 1;
      else stalls++;
    end
    if (!done) check("issue_timeout", 1'b0, 1'b1);
    req_valid = 0;
  endtask

  task automatic drain();
    int i = 0;
    while ((wb_count != 0 || exp_q.size() != 0 || exp_rf.size() != 0) && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_count", wb_count, 0);
    check("drain_txn_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    mem[32'h104] = 32'hDEADBEEF;
    exp_mem[32'h104] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_count", wb_count, 0);
    check("rst_refill_valid", refill_valid, 0);
    check("rst_refill_data", refill_data, 0);
    @(posedge clk); #1 rst = 0;

    // reset while a read is outstanding
    hold = 1;
    req_valid = 1; req_wen = 0; req_addr = 32'h200; cache_hit = 0; req_width = 0;
    repeat (3) @(negedge clk);
    check("t1_stall", stall, 1);
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 32'h200);
    #2 rst = 1;
    #1;
    check("t1_async_stall", stall, 0);
    check("t1_async_mem_req", mem_req, 0);
    check("t1_async_wb_count", wb_count, 0);
    req_valid = 0; hold = 0;
    exp_q.delete(); exp_rf.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("t1_refill_valid", refill_valid, 0);
    check("t1_idle_mem_req", mem_req, 0);
    @(posedge clk); #1;

    // load miss, empty buffer, ack on the third read cycle
    ack_delay = 3;
    issue(0, 32'h104, 0, 3'b000, 0, st);
    check("t2_stall_cycles", st, 4);
    drain();

    // store then load miss to same word: write must precede read
    ack_delay = 2;
    issue(1, 32'h10, 32'h11223344, 3'b000, 0, st);
    check("t3_store_stall", st, 0);
    issue(0, 32'h10, 0, 3'b000, 0, st);
    drain();

    // five byte stores against a stalled memory
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      issue(1, 32'h20 + i, 32'hA0 + i, 3'b010, 0, st);
      check("t4_store_stall", st, 0);
      check("t4_wb_count", wb_count, i + 1);
    end
    drive(1, 32'h24, 32'hA4, 3'b010, 0);
    @(negedge clk); #1;
    check("t4_full_stall", stall, 1);
    check("t4_full_count", wb_count, 4);
    @(posedge clk); #1;
    ack_delay = 1; hold = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (mem_ack) break;
    end
    check("t4_ack_seen", mem_ack, 1);
    check("t4_stall_on_ack", stall, 1);
    @(negedge clk); #1;
    check("t4_stall_after_ack", stall, 0);
    check("t4_count_after_ack", wb_count, 3);
    @(posedge clk); #1;
    req_valid = 0;
    check("t4_count_refill", wb_count, 4);
    drain();

    // load hit while writes are queued
    hold = 1;
    issue(1, 32'h42, 32'hAAAA5555, 3'b001, 0, st);
    issue(1, 32'h44, 32'hCAFEF00D, 3'b000, 0, st);
    issue(0, 32'h40, 0, 3'b000, 1, st);
    check("t5_hit_stall", st, 0);
    @(negedge clk);
    check("t5_mem_we", mem_we, 1);
    check("t5_wb_count", wb_count, 2);
    @(posedge clk); #1;
    hold = 0;
    issue(0, 32'h40, 0, 3'b101, 0, st);
    drain();

    // push and pop in the same cycle, then wrap the pointers
    hold = 1; ack_delay = 1;
    issue(1, 32'h80, 32'h1, 3'b000, 0, st);
    issue(1, 32'h84, 32'h2, 3'b000, 0, st);
    drive(1, 32'h88, 32'h3, 3'b000, 0);
    hold = 0;
    @(negedge clk); #1;
    check("t6_ack", mem_ack, 1);
    check("t6_no_stall", stall, 0);
    @(posedge clk); #1;
    hold = 1; req_valid = 0;
    check("t6_count_kept", wb_count, 2);
    issue(1, 32'h8C, 32'h4, 3'b000, 0, st);
    issue(1, 32'h91, 32'h55, 3'b110, 0, st);
    check("t6_count_full", wb_count, 4);
    hold = 0;
    drain();
    issue(0, 32'h90, 0, 3'b000, 0, st);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
